// File: rtl/rx_ptp_buf_pkg.sv
// Shared XGMII codes, buffer geometry, FSM states and status layout for the
// PTP receive frame buffer.
package rx_ptp_buf_pkg;

    localparam logic [7:0] XGMII_START    = 8'hFB;
    localparam logic [7:0] XGMII_TERM     = 8'hFD;
    localparam logic [7:0] XGMII_IDLE     = 8'h07;
    localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
    localparam logic [7:0] XGMII_SFD      = 8'hD5;
    localparam logic [7:0] XGMII_ERROR    = 8'hFE;

    localparam logic [63:0] XGMII_START_WORD = {XGMII_SFD, {6{XGMII_PREAMBLE}}, XGMII_START};

    localparam int unsigned BUF_WORDS = 128;
    localparam int unsigned BUF_AW    = 7;
    localparam int unsigned LEN_W     = 10;
    localparam int unsigned CNT_W     = 11;

    localparam logic [31:0] WIN_SIZE   = 32'h200;
    localparam logic [31:0] STATUS_OFS = 32'h200;
    localparam logic [31:0] DROP_OFS   = 32'h204;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_DROP
    } rx_state_e;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic        frm_rdy;
        logic        err;
        logic [3:0]  rsvd_lo;
        logic [9:0]  frm_len;
    } rx_status_t;

endpackage

// File: rtl/rx_ptp_buf_if.sv
// XGMII receive lanes plus the register bus of the PTP receive buffer.
interface rx_ptp_buf_if;

    logic [63:0] xge_rxd_i;
    logic [7:0]  xge_rxc_i;
    logic [31:0] bus2ip_addr_i;
    logic [31:0] bus2ip_data_i;
    logic        bus2ip_rd_ce_i;
    logic        bus2ip_wr_ce_i;
    logic [31:0] ip2bus_data_o;
    logic        rx_frm_rdy_o;

    modport master (
        output xge_rxd_i, xge_rxc_i, bus2ip_addr_i, bus2ip_data_i,
               bus2ip_rd_ce_i, bus2ip_wr_ce_i,
        input  ip2bus_data_o, rx_frm_rdy_o
    );

    modport slave (
        input  xge_rxd_i, xge_rxc_i, bus2ip_addr_i, bus2ip_data_i,
               bus2ip_rd_ce_i, bus2ip_wr_ce_i,
        output ip2bus_data_o, rx_frm_rdy_o
    );

endinterface

// File: rtl/rx_ptp_buf.sv
// Captures one XGMII receive frame into a 128x32 buffer and exposes it, a
// status register and a saturating drop counter on the register bus.
module rx_ptp_buf
    import rx_ptp_buf_pkg::*;
#(
    parameter logic [31:0] RX_BUF_BADDR = 32'h3000,
    parameter int unsigned MAX_LEN      = 512
) (
    input logic        rx_clk,
    input logic        rx_rst,
    rx_ptp_buf_if.slave bus
);

    rx_state_e         state_q, state_d;
    logic [31:0]       mem [BUF_WORDS];
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_sum;
    logic [LEN_W-1:0]  frm_len_q;
    logic              rdy_q, err_q;
    logic [7:0]        drop_q;

    logic [2:0]        ctl_lane;
    logic              has_ctl, term_hit, fd_any, start_hit, start_ok;
    logic [63:0]       term_data;
    logic              wr_full, wr_term, commit, err_set, drop_inc;
    logic [31:0]       offset;
    logic              stat_wr, drop_wr;
    logic [BUF_AW-1:0] widx;
    rx_status_t        status;

    // Lane decode: lowest control lane, terminate detection, byte count update
    always_comb begin
        ctl_lane = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bus.xge_rxc_i[i]) ctl_lane = 3'(i);
        end
        has_ctl  = |bus.xge_rxc_i;
        term_hit = has_ctl && (bus.xge_rxd_i[8*ctl_lane +: 8] == XGMII_TERM);
        fd_any   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.xge_rxc_i[i] && (bus.xge_rxd_i[8*i +: 8] == XGMII_TERM)) fd_any = 1'b1;
        end
        start_hit = (bus.xge_rxc_i == 8'h01) && (bus.xge_rxd_i[7:0] == XGMII_START);
        start_ok  = (bus.xge_rxd_i == XGMII_START_WORD);
        cnt_sum   = cnt_q + (has_ctl ? CNT_W'(ctl_lane) : CNT_W'(8));
        // Lanes at or above the terminate lane are written as zero
        term_data = bus.xge_rxd_i;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) >= ctl_lane) term_data[8*i +: 8] = 8'h00;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) state_q <= RX_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_full  = 1'b0;
        wr_term  = 1'b0;
        commit   = 1'b0;
        err_set  = 1'b0;
        drop_inc = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (start_hit) begin
                    if (!start_ok) begin
                        state_d = RX_DROP;
                    end else if (rdy_q) begin
                        state_d  = RX_DROP;
                        drop_inc = 1'b1;
                    end else begin
                        state_d = RX_DATA;
                        cnt_d   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (cnt_sum > CNT_W'(MAX_LEN)) begin
                    err_set = 1'b1;
                    state_d = RX_DROP;
                end else if (!has_ctl) begin
                    wr_full = !rdy_q;
                    cnt_d   = cnt_sum;
                end else if (term_hit) begin
                    wr_term = !rdy_q;
                    commit  = 1'b1;
                    cnt_d   = cnt_sum;
                    state_d = RX_IDLE;
                end else begin
                    err_set = 1'b1;
                    state_d = RX_DROP;
                end
            end
            RX_DROP: begin
                if (fd_any) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign widx = cnt_q[8:2];

    // Frame storage; byte counter is always a multiple of 8 while in RX_DATA
    always_ff @(posedge rx_clk) begin
        if (wr_full) begin
            mem[widx]         <= bus.xge_rxd_i[31:0];
            mem[widx + 7'd1]  <= bus.xge_rxd_i[63:32];
        end else if (wr_term) begin
            if (ctl_lane != 3'd0) mem[widx]        <= term_data[31:0];
            if (ctl_lane > 3'd4)  mem[widx + 7'd1] <= term_data[63:32];
        end
    end

    assign offset  = bus.bus2ip_addr_i - RX_BUF_BADDR;
    assign stat_wr = bus.bus2ip_wr_ce_i && (offset == STATUS_OFS);
    assign drop_wr = bus.bus2ip_wr_ce_i && (offset == DROP_OFS);

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            cnt_q     <= '0;
            frm_len_q <= '0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (commit) begin
                rdy_q     <= 1'b1;
                frm_len_q <= cnt_sum[LEN_W-1:0];
            end else if (stat_wr && bus.bus2ip_data_i[15]) begin
                rdy_q <= 1'b0;
            end
            if (err_set)                                err_q <= 1'b1;
            else if (stat_wr && bus.bus2ip_data_i[14]) err_q <= 1'b0;
            if (drop_wr)                                drop_q <= '0;
            else if (drop_inc && (drop_q != 8'hFF))     drop_q <= drop_q + 8'd1;
        end
    end

    // Combinational read mux
    always_comb begin
        status         = '0;
        status.frm_rdy = rdy_q;
        status.err     = err_q;
        status.frm_len = frm_len_q;
        bus.ip2bus_data_o = '0;
        if (bus.bus2ip_rd_ce_i) begin
            if (offset < WIN_SIZE)          bus.ip2bus_data_o = mem[offset[8:2]];
            else if (offset == STATUS_OFS)  bus.ip2bus_data_o = status;
            else if (offset == DROP_OFS)    bus.ip2bus_data_o = {24'h0, drop_q};
        end
    end

    assign bus.rx_frm_rdy_o = rdy_q;

endmodule
